// File: rtl/score_packer.sv
// Serial-to-parallel score packer: saturates incoming accumulator scores,
// assembles a frame in a shadow buffer and publishes it as one packed bus.
module score_packer #(
    parameter int DATA_WIDTH  = 29,
    parameter int NUM_CLASS   = 10,
    parameter int IN_WIDTH    = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [IN_WIDTH-1:0]             score_in,
    input  logic                            score_valid,
    input  logic                            frame_start,
    output logic                            in_ready,
    output logic [DATA_WIDTH*NUM_CLASS-1:0] layer_out,
    output logic                            valid,
    output logic                            frame_err
);

    localparam int IDX_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int UP_W  = IN_WIDTH - DATA_WIDTH + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASS - 1);
    localparam logic [IDX_W-1:0] FIRST_NXT = IDX_W'(1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        hold_cnt;
    logic [DATA_WIDTH-1:0]   shadow [NUM_CLASS];
    logic [UP_W-1:0]         upper;
    logic [DATA_WIDTH-1:0]   sat_score;
    logic [DATA_WIDTH*NUM_CLASS-1:0] final_bus;
    logic                    accept;

    assign accept = score_valid & in_ready;
    assign upper  = score_in[IN_WIDTH-1 -: UP_W];

    // The score fits when every bit above the target sign bit equals it.
    always_comb begin
        if (&upper || ~|upper)
            sat_score = score_in[DATA_WIDTH-1:0];
        else if (upper[UP_W-1])
            sat_score = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat_score = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    // Completed frame: stored slots plus the final score still in flight.
    always_comb begin
        final_bus = '0;
        for (int unsigned i = 0; i < NUM_CLASS - 1; i++)
            final_bus[i*DATA_WIDTH +: DATA_WIDTH] = shadow[i];
        final_bus[(NUM_CLASS-1)*DATA_WIDTH +: DATA_WIDTH] = sat_score;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            in_ready  <= 1'b1;
            layer_out <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLASS; i++)
                shadow[i] <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (frame_start) begin
                            shadow[0] <= sat_score;
                            idx       <= FIRST_NXT;
                            state     <= COLLECT;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            shadow[0] <= sat_score;
                            idx       <= FIRST_NXT;
                        end else if (idx == LAST_IDX) begin
                            shadow[idx] <= sat_score;
                            layer_out   <= final_bus;
                            valid       <= 1'b1;
                            in_ready    <= 1'b0;
                            hold_cnt    <= HOLD_INIT;
                            idx         <= '0;
                            state       <= HOLD;
                        end else begin
                            shadow[idx] <= sat_score;
                            idx         <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_packer.sv
// Scoreboard bench for score_packer: a frame-level model predicts published
// frames and protocol errors with their due cycles; a monitor checks them.
module tb_score_packer;

    localparam int DW = 29;
    localparam int NC = 10;
    localparam int IW = 32;
    localparam int HC = 2;

    typedef logic [DW*NC-1:0] frame_t;
    typedef struct {
        frame_t data;
        int     due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] score_in = '0;
    logic          score_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_ready;
    frame_t        layer_out;
    logic          valid;
    logic          frame_err;

    score_packer #(
        .DATA_WIDTH (DW),
        .NUM_CLASS  (NC),
        .IN_WIDTH   (IW),
        .HOLD_CYCLES(HC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .score_in   (score_in),
        .score_valid(score_valid),
        .frame_start(frame_start),
        .in_ready   (in_ready),
        .layer_out  (layer_out),
        .valid      (valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    exp_t   exp_q[$];
    int     err_q[$];
    frame_t published = '0;

    // Reference model state: frame in progress and remaining busy cycles.
    logic [DW-1:0] mbuf[$];
    bit            m_collect = 0;
    int            m_busy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] sat(input logic [IW-1:0] s);
        longint v, mx, mn;
        v  = longint'($signed(s));
        mx = (longint'(1) <<< (DW - 1)) - 1;
        mn = -(longint'(1) <<< (DW - 1));
        if (v > mx) return DW'(mx);
        if (v < mn) return DW'(mn);
        return DW'(v);
    endfunction

    function automatic frame_t pack(input logic [DW-1:0] q[$]);
        frame_t f;
        f = '0;
        foreach (q[i]) f[i*DW +: DW] = q[i];
        return f;
    endfunction

    // One clock of stimulus; the model decides what the next edge must do.
    task automatic step(input bit v, input bit fs, input logic [IW-1:0] s);
        exp_t e;
        score_valid = v;
        frame_start = fs;
        score_in    = s;
        checks++;
        if (in_ready !== (m_busy == 0)) begin
            errors++;
            $display("FAIL in_ready cyc=%0d got %b want %b", cyc, in_ready, m_busy == 0);
        end
        if (m_busy > 0) begin
            m_busy--;
        end else if (v) begin
            if (fs) begin
                if (m_collect) err_q.push_back(cyc + 1);
                mbuf.delete();
                mbuf.push_back(sat(s));
                m_collect = 1;
            end else if (!m_collect) begin
                err_q.push_back(cyc + 1);
            end else begin
                mbuf.push_back(sat(s));
                if (mbuf.size() == NC) begin
                    e.data = pack(mbuf);
                    e.due  = cyc + 1;
                    exp_q.push_back(e);
                    mbuf.delete();
                    m_collect = 0;
                    m_busy = 1 + HC;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        score_valid = 1'b0;
        frame_start = 1'b0;
        score_in = '0;
        mbuf.delete();
        m_collect = 0;
        m_busy = 0;
        exp_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || valid !== 1'b0 || frame_err !== 1'b0 || layer_out !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b err=%b out=%h want 1 0 0 0",
                     in_ready, valid, frame_err, layer_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, $urandom);
    endtask

    function automatic logic [IW-1:0] rnd_score();
        case ($urandom_range(3))
            0: return $urandom;
            1: return IW'($signed(int'($urandom_range(2000)) - 1000));
            2: return 32'h0FFF_FFFF + IW'($urandom_range(2)) - 32'd1;
            default: return 32'hF000_0000 + IW'($urandom_range(2)) - 32'd1;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n !== 1'b1) begin
            published = '0;
        end else begin
            if (valid === 1'b1 && frame_err === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL valid_and_err cyc=%0d both high", cyc);
            end
            checks++;
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d out=%h", cyc, layer_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != cyc || layer_out !== e.data) begin
                        errors++;
                        $display("FAIL frame cyc=%0d got %h want %h due=%0d", cyc, layer_out, e.data, e.due);
                    end
                    published = e.data;
                end
            end else if (layer_out !== published) begin
                errors++;
                $display("FAIL layer_hold cyc=%0d got %h want %h", cyc, layer_out, published);
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid cyc=%0d due=%0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (frame_err === 1'b1) begin
                checks++;
                if (err_q.size() == 0 || err_q[0] != cyc) begin
                    errors++;
                    $display("FAIL unexpected_err cyc=%0d want_due=%0d", cyc,
                             (err_q.size() > 0) ? err_q[0] : -1);
                end
                if (err_q.size() > 0) void'(err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_err cyc=%0d due=%0d", cyc, err_q[0]);
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        logic [IW-1:0] sat_tab [6];
        sat_tab = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1000_0000,
                    32'hEFFF_FFFF, 32'h0FFF_FFFF, 32'hF000_0000};

        reset_cycle();

        // Ascending frame
        for (int i = 0; i < NC; i++) step(1, i == 0, IW'(i));
        idle(4);

        // Saturation boundaries
        for (int i = 0; i < NC; i++) step(1, i == 0, (i < 6) ? sat_tab[i] : 32'd5);
        idle(4);

        // Stray score in IDLE, then a clean frame
        step(1, 0, 32'd7);
        idle(1);
        for (int i = 0; i < NC; i++) step(1, i == 0, 32'd100);
        idle(4);

        // Restart at the 5th score
        for (int i = 0; i < 4; i++) step(1, i == 0, 32'd50);
        for (int i = 0; i < NC; i++) step(1, i == 0, 32'hFFFF_FFFD);

        // Producer ignores in_ready through the hold window
        for (int i = 0; i < 1 + HC; i++) step(1, 0, $urandom);
        for (int i = 0; i < NC; i++) step(1, i == 0, IW'(i * 3));
        idle(4);

        // Reset mid-frame
        for (int i = 0; i < 6; i++) step(1, i == 0, 32'd9);
        reset_cycle();
        idle(2);
        for (int i = 0; i < NC; i++) step(1, i == 0, IW'(20 + i));
        idle(4);

        // Randomized frames with gaps, restarts and hold-window pressure
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(15) == 0) step(1, 0, rnd_score());
            for (int k = 0; k < NC; k++) begin
                while ($urandom_range(3) == 0) step(0, $urandom_range(1), rnd_score());
                step(1, (k == 0) || ($urandom_range(25) == 0), rnd_score());
            end
            for (int i = 0; i < 1 + HC; i++) step($urandom_range(1), 0, rnd_score());
        end
        idle(6);

        checks++;
        if (exp_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL drain got frames=%0d errs=%0d want 0 0", exp_q.size(), err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_packer.md
Name: score_packer

Overview:
- Producer-side front end of the classifier's argmax stage.
- Takes NUM_CLASS final-layer scores arriving serially from the output neuron accumulator, one per accepted beat.
- Saturates each score from IN_WIDTH to DATA_WIDTH signed bits and assembles them in a shadow buffer.
- On completion, publishes them as one packed bus with a single-cycle valid pulse, then holds the bus stable long enough for the downstream argmax comparator to produce its prediction.

Parameters:
DATA_WIDTH, 29, signed width of each packed score slot
NUM_CLASS, 10, number of scores per frame
IN_WIDTH, 32, signed width of incoming accumulator scores (IN_WIDTH >= DATA_WIDTH)
HOLD_CYCLES, 2, cycles after valid during which layer_out is frozen and no input is accepted

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
score_in  input  IN_WIDTH  signed two's-complement score from output accumulator
score_valid  input  1  score_in presented this cycle
frame_start  input  1  qualifies the first score of a frame; sampled only when score_valid=1
in_ready  output  1  block accepts a score this cycle; accept = score_valid & in_ready
layer_out  output  DATA_WIDTH*NUM_CLASS  packed scores; class i at bits [i*DATA_WIDTH +: DATA_WIDTH]
valid  output  1  one-cycle pulse: layer_out holds a complete new frame
frame_err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - layer_out=0, valid=0, frame_err=0, in_ready=1.
  - Shadow buffer cleared, idx=0, state=IDLE.
  - Reset mid-frame or mid-HOLD discards all partial data; no valid is issued.
- Saturation, per accepted score:
  - score_in > 2^(DATA_WIDTH-1)-1 -> 0x0FFFFFFF (default widths).
  - score_in < -2^(DATA_WIDTH-1) -> 0x10000000.
  - Otherwise -> score_in[DATA_WIDTH-1:0].
- State IDLE (in_ready=1):
  - Accept with frame_start=1: write sat(score_in) to shadow[0], idx<=1, go to COLLECT.
  - Accept with frame_start=0: score dropped, frame_err pulses next cycle, stay in IDLE.
- State COLLECT (in_ready=1):
  - Accept with frame_start=0: shadow[idx]<=sat(score_in), idx<=idx+1.
  - Accept with frame_start=1: abandon partial frame, frame_err pulses, shadow[0]<=sat(score_in), idx<=1, stay in COLLECT.
  - Accept when idx=NUM_CLASS-1 (and frame_start=0): write the last slot, then copy the whole shadow buffer (including this final score) to layer_out in the same edge.
    - valid=1 for exactly the next cycle.
    - Go to HOLD with hold counter = HOLD_CYCLES.
  - Cycles with score_valid=0 change nothing; there is no timeout.
- State HOLD (in_ready=0):
  - Entered on the cycle valid is high; in_ready=0 from that cycle.
  - layer_out is frozen; incoming score_valid is ignored (the producer must respect in_ready, so nothing is flagged).
  - Counter decrements each cycle; at 0, go to IDLE with in_ready=1.
  - Total in_ready-low window = 1 + HOLD_CYCLES cycles, starting with the valid cycle.
- Latency:
  - Last accepted score at edge N -> valid and new layer_out visible after edge N.
  - layer_out stays unchanged until the next frame completes.
  - Minimum frame period is NUM_CLASS + 1 + HOLD_CYCLES cycles.
- Timing constraints:
  - The downstream comparator registers layer_out every cycle and raises its ready 2 cycles after valid, so HOLD_CYCLES >= 2 is mandatory.
  - valid and frame_err are never high in the same cycle.
  - idx never exceeds NUM_CLASS-1.

Test Plan:
- Reset, then frame of scores 0,1,...,9 with frame_start on the first -> valid high exactly 1 cycle, 1 cycle after the 10th accept; slot i = i; in_ready low for 3 cycles starting at the valid cycle.
- Scores 0x7FFFFFFF, 0x80000000, 0x10000000, 0xEFFFFFFF, 0x0FFFFFFF, 0xF0000000, rest 5 -> slots 0x0FFFFFFF, 0x10000000, 0x0FFFFFFF, 0x10000000, 0x0FFFFFFF, 0x10000000, 5.
- Score offered in IDLE without frame_start (value 7), then a valid frame of 100s -> one frame_err pulse; all 10 slots = 100; no stray 7 anywhere.
- frame_start re-asserted at the 5th score, then 10 scores of -3 -> one frame_err; a single valid; all slots 0x1FFFFFFD.
- Producer ignores in_ready and drives score_valid continuously during HOLD -> no data accepted, layer_out unchanged for the 3 cycles, no frame_err; the next frame starts cleanly.
- rst_n low for 1 cycle after 6 of 10 scores, then a full frame -> valid only once, for the post-reset frame; layer_out = 0 until then.
